rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two writeback requesters: req0 is the ALU/execute path and req1 is the load/memory path.
- Round-robin arbitration, valid/ready handshake per requester.
- One registered output stage drives the register file's reg_write/write_reg/write_data.
- Exposes the in-flight write (pending mask plus forwarding fields) so hazard logic can see a write that has not yet committed.
- A hold input freezes the port, e.g. while a test loader owns the register file.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register index width (32 registers)
CNT_W, 16, width of committed-write counter

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state immediately
req0_valid  in  1  ALU path has a writeback
req0_rd  in  ADDR_W  destination register
req0_data  in  DATA_W  value to write
req0_ready  out  1  request accepted this cycle
req1_valid  in  1  load path has a writeback
req1_rd  in  ADDR_W  destination register
req1_data  in  DATA_W  value to write
req1_ready  out  1  request accepted this cycle
hold  in  1  freeze write port and output stage
rf_reg_write  out  1  to register file reg_write
rf_write_reg  out  ADDR_W  to register file write_reg
rf_write_data  out  DATA_W  to register file write_data
pending_mask  out  32  one-hot of out-stage rd when out_valid, else 0
fwd_valid  out  1  equals out_valid
fwd_rd  out  ADDR_W  equals out_rd
fwd_data  out  DATA_W  equals out_data
write_count  out  CNT_W  number of committed writes, wraps

Behaviour:
- State: out_valid, out_rd, out_data, last_grant (1 bit), write_count.
- Reset (async, active-high) values:
  - out_valid=0, out_rd=0, out_data=0.
  - last_grant=1, so req0 wins the first conflict.
  - write_count=0.
  - While reset is high: all outputs 0 and both readies 0.
- Grant is combinational and only computed when hold=0:
  - Only req0_valid → grant0. Only req1_valid → grant1.
  - Both valid → grant the requester that is not last_grant.
  - Neither valid → no grant.
  - req0_ready=grant0; req1_ready=grant1. At most one ready per cycle; ready never asserts without valid.
- hold=1:
  - Both readies=0 and no grant.
  - rf_reg_write=0.
  - out_valid/out_rd/out_data and last_grant keep their values.
  - write_count unchanged.
- Output stage, on posedge with hold=0:
  - out_valid <= grant && granted_rd != 0.
  - out_rd/out_data <= granted rd/data. With no grant, out_rd/out_data are held.
  - last_grant <= granted index, if any grant.
- Write to x0: accepted (ready=1), consumes the grant and advances last_grant, produces no write (out_valid=0 next cycle).
- rf_reg_write = out_valid && !hold. rf_write_reg=out_rd, rf_write_data=out_data.
  - Latency: accepted request → rf_reg_write high the next cycle → register file commits at the following edge.
- Throughput: one accept per cycle. The output stage always drains when hold=0, so back-to-back accepts never stall.
- write_count increments on every posedge with rf_reg_write=1 and wraps at 2^CNT_W.
- Same-rd requests from both paths in one cycle: arbitration order decides, and the later grant's write lands last. Ordering is the pipeline's responsibility.
- A request is held stable by its requester until ready. Changing rd/data while valid and not ready is illegal (bench asserts).
- Hold released: any held out_valid entry writes in the first cycle with hold=0; a new grant is possible in that same cycle.
- Reset mid-operation: a pending out-stage write is discarded and never written.

Decomposition:
- Shared package:
  - ADDR_W/DATA_W defaults.
  - REQ_ALU=0 and REQ_LOAD=1 index constants.
  - A writeback request struct {valid, rd, data}, reused by the pipeline writeback stages.
- One natural sub-module: rr_arbiter2 — the 2-way round-robin grant logic plus the last_grant flop, with an advance enable tied to !hold.

Test Plan:
1. Reset high, drive req0_valid=1 → readies 0, rf_reg_write=0, write_count=0. Release reset, req0 rd=5 data=0xDEADBEEF → req0_ready=1 that cycle; next cycle rf_reg_write=1, rf_write_reg=5, rf_write_data=0xDEADBEEF, pending_mask=0x00000020; write_count=1 after that edge.
2. Both valid every cycle with req0 rd=3 and req1 rd=4, each requester advancing its data when its ready is seen → grants req0,req1,req0,req1 starting with req0; rf_write_reg sequence 3,4,3,4 one cycle later; no bubbles.
3. req1 rd=0 data=0x1234 alone → req1_ready=1, next cycle rf_reg_write=0 and pending_mask=0. A following conflict then grants req0.
4. Accept req0 rd=7 data=0x55, then hold=1 for 3 cycles with both requests valid → readies 0, rf_reg_write=0, fwd_rd=7, pending_mask=0x80. Hold falls → rf_reg_write=1 with rd=7 and req1_ready=1 in that same cycle.
5. Accept req0 rd=9, then assert reset mid-cycle before the commit edge → rf_reg_write drops to 0 immediately; register 9 is never written; after release the first conflict grants req0.
6. Issue 2^CNT_W+2 writes with CNT_W overridden to 4 → write_count wraps to 2.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_pkg
// Description : Shared widths, requester indices and writeback request type
//               for the register-file write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_if
// Description : Requester handshakes, hold, register-file write port and
//               hazard-visibility signals of the write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int CNT_W  = 16
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_rd;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_rd;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              hold;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [31:0]       pending_mask;
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  write_count;

  modport master (
    output req0_valid, req0_rd, req0_data,
    output req1_valid, req1_rd, req1_data,
    output hold,
    input  req0_ready, req1_ready,
    input  rf_reg_write, rf_write_reg, rf_write_data,
    input  pending_mask, fwd_valid, fwd_rd, fwd_data, write_count
  );

  modport slave (
    input  req0_valid, req0_rd, req0_data,
    input  req1_valid, req1_rd, req1_data,
    input  hold,
    output req0_ready, req1_ready,
    output rf_reg_write, rf_write_reg, rf_write_data,
    output pending_mask, fwd_valid, fwd_rd, fwd_data, write_count
  );

endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant with its last-grant flop; the flop
//               only advances when a grant is issued with en_i high.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import rf_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // On a conflict the requester that did not win last time is preferred.
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (req_i[REQ_ALU] && req_i[REQ_LOAD]) begin
        if (last_grant_q) grant_o[REQ_ALU]  = 1'b1;
        else              grant_o[REQ_LOAD] = 1'b1;
      end else begin
        grant_o = req_i;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_o != 2'b00) last_grant_d = grant_o[REQ_LOAD];
  end

  // Reset value makes req0 the winner of the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the register-file write port between the ALU and load
//               writeback paths through one registered output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int CNT_W  = 16
)(
  input  logic              clk,
  input  logic              reset,
  rf_write_arbiter_if.slave bus
);

  logic [1:0]        grant;
  logic              grant_any;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic              rf_we;
  logic [31:0]       pending;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_rd_q,    out_rd_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0]  count_q,     count_d;

  // Gating with reset keeps both readies low while reset is held.
  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en_i    (!bus.hold && !reset),
    .req_i   ({bus.req1_valid, bus.req0_valid}),
    .grant_o (grant)
  );

  assign grant_any = |grant;
  assign sel_rd    = grant[REQ_LOAD] ? bus.req1_rd   : bus.req0_rd;
  assign sel_data  = grant[REQ_LOAD] ? bus.req1_data : bus.req0_data;

  // A grant to x0 is consumed but leaves the stage empty.
  always_comb begin
    out_valid_d = out_valid_q;
    out_rd_d    = out_rd_q;
    out_data_d  = out_data_q;
    if (!bus.hold) begin
      out_valid_d = grant_any && (sel_rd != '0);
      if (grant_any) begin
        out_rd_d   = sel_rd;
        out_data_d = sel_data;
      end
    end
  end

  assign rf_we   = out_valid_q && !bus.hold;
  assign count_d = count_q + CNT_W'(rf_we);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_rd_q    <= '0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rd_q    <= out_rd_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
    end
  end

  for (genvar gi = 0; gi < RF_NUM_REGS; gi++) begin : g_pending
    assign pending[gi] = out_valid_q && (out_rd_q == ADDR_W'(gi));
  end

  assign bus.req0_ready    = grant[REQ_ALU];
  assign bus.req1_ready    = grant[REQ_LOAD];
  assign bus.rf_reg_write  = rf_we;
  assign bus.rf_write_reg  = out_rd_q;
  assign bus.rf_write_data = out_data_q;
  assign bus.pending_mask  = pending;
  assign bus.fwd_valid     = out_valid_q;
  assign bus.fwd_rd        = out_rd_q;
  assign bus.fwd_data      = out_data_q;
  assign bus.write_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed scenarios plus randomized traffic against a
//               transaction-level model of the write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;
  import rf_write_arbiter_pkg::*;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: who won last, what sits in the write slot, how many commits.
  int          m_last;
  bit          m_pv;
  logic [4:0]  m_prd;
  logic [31:0] m_pdata;
  int          m_cnt;
  bit          written [32];

  function automatic int winner();
    if (reset || bus.hold) return -1;
    if (bus.req0_valid && bus.req1_valid) return 1 - m_last;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_last = 1; m_pv = 0; m_prd = '0; m_pdata = '0; m_cnt = 0;
  endtask

  task automatic tick();
    int w;
    w = winner();
    if (!reset && !bus.hold) begin
      if (m_pv) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_pv = 0;
      if (w >= 0) begin
        m_last  = w;
        m_prd   = (w == 1) ? bus.req1_rd   : bus.req0_rd;
        m_pdata = (w == 1) ? bus.req1_data : bus.req0_data;
        m_pv    = (m_prd != 0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 0; bus.req0_rd = '0; bus.req0_data = '0;
    bus.req1_valid = 0; bus.req1_rd = '0; bus.req1_data = '0;
    bus.hold = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  // Register-file shadow: a write seen at negedge commits at the next edge.
  always @(negedge clk) if (!reset && bus.rf_reg_write) written[bus.rf_write_reg] = 1'b1;

  // Requester protocol: rd/data must not move while valid and unaccepted.
  logic        p_v0, p_r0, p_v1, p_r1;
  logic [4:0]  p_rd0, p_rd1;
  logic [31:0] p_d0, p_d1;
  bit          p_ok = 0;
  always @(negedge clk) begin
    if (!reset && p_ok) begin
      if (p_v0 && !p_r0 && bus.req0_valid && (bus.req0_rd !== p_rd0 || bus.req0_data !== p_d0)) begin
        n_fail++; $display("FAIL req0_stable: rd %0d data %h, required rd %0d data %h", bus.req0_rd, bus.req0_data, p_rd0, p_d0);
      end
      if (p_v1 && !p_r1 && bus.req1_valid && (bus.req1_rd !== p_rd1 || bus.req1_data !== p_d1)) begin
        n_fail++; $display("FAIL req1_stable: rd %0d data %h, required rd %0d data %h", bus.req1_rd, bus.req1_data, p_rd1, p_d1);
      end
    end
    p_v0 = bus.req0_valid; p_r0 = bus.req0_ready; p_rd0 = bus.req0_rd; p_d0 = bus.req0_data;
    p_v1 = bus.req1_valid; p_r1 = bus.req1_ready; p_rd1 = bus.req1_rd; p_d1 = bus.req1_data;
    p_ok = !reset;
  end

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    model_reset();
    bus.req0_valid = 1; bus.req0_rd = 5'd5; bus.req0_data = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0: got %b want 0", bus.req0_ready); end
    n_tests++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready1: got %b want 0", bus.req1_ready); end
    n_tests++; if (bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", bus.rf_reg_write); end
    n_tests++; if (bus.write_count !== 4'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", bus.write_count); end
    n_tests++; if (bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL rst_mask: got %h want 0", bus.pending_mask); end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    n_tests++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL first_ready0: got %b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 0;
    @(negedge clk);
    n_tests++; if (bus.rf_reg_write !== 1'b1) begin n_fail++; $display("FAIL first_we: got %b want 1", bus.rf_reg_write); end
    n_tests++; if (bus.rf_write_reg !== 5'd5) begin n_fail++; $display("FAIL first_reg: got %0d want 5", bus.rf_write_reg); end
    n_tests++; if (bus.rf_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL first_data: got %h want deadbeef", bus.rf_write_data); end
    n_tests++; if (bus.pending_mask !== 32'h0000_0020) begin n_fail++; $display("FAIL first_mask: got %h want 00000020", bus.pending_mask); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.write_count !== 4'd1) begin n_fail++; $display("FAIL first_count: got %0d want 1", bus.write_count); end
    n_tests++; if (bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL first_idle_we: got %b want 0", bus.rf_reg_write); end
  endtask

  task automatic test_round_robin();
    logic [31:0] d0, d1, prev_data;
    int prev_rd;
    do_reset();
    d0 = 32'h100; d1 = 32'h200; prev_rd = -1; prev_data = '0;
    bus.req0_valid = 1; bus.req0_rd = 5'd3; bus.req0_data = d0;
    bus.req1_valid = 1; bus.req1_rd = 5'd4; bus.req1_data = d1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_tests++; if (bus.req0_ready !== (k % 2 == 0)) begin n_fail++; $display("FAIL rr_ready0[%0d]: got %b want %b", k, bus.req0_ready, k % 2 == 0); end
      n_tests++; if (bus.req1_ready !== (k % 2 == 1)) begin n_fail++; $display("FAIL rr_ready1[%0d]: got %b want %b", k, bus.req1_ready, k % 2 == 1); end
      if (k > 0) begin
        n_tests++; if (bus.rf_reg_write !== 1'b1) begin n_fail++; $display("FAIL rr_we[%0d]: got %b want 1", k, bus.rf_reg_write); end
        n_tests++; if (bus.rf_write_reg !== 5'(prev_rd)) begin n_fail++; $display("FAIL rr_reg[%0d]: got %0d want %0d", k, bus.rf_write_reg, prev_rd); end
        n_tests++; if (bus.rf_write_data !== prev_data) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, bus.rf_write_data, prev_data); end
      end
      if (k % 2 == 0) begin prev_rd = 3; prev_data = d0; d0 = d0 + 1; end
      else            begin prev_rd = 4; prev_data = d1; d1 = d1 + 1; end
      tick();
      bus.req0_data = d0;
      bus.req1_data = d1;
    end
    clear_inputs();
    @(negedge clk);
    n_tests++; if (bus.rf_write_reg !== 5'd4) begin n_fail++; $display("FAIL rr_last_reg: got %0d want 4", bus.rf_write_reg); end
    n_tests++; if (bus.write_count !== 4'd7) begin n_fail++; $display("FAIL rr_count: got %0d want 7", bus.write_count); end
  endtask

  task automatic test_x0();
    do_reset();
    bus.req1_valid = 1; bus.req1_rd = 5'd0; bus.req1_data = 32'h1234;
    @(negedge clk);
    n_tests++; if (bus.req1_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready1: got %b want 1", bus.req1_ready); end
    n_tests++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL x0_ready0: got %b want 0", bus.req0_ready); end
    tick();
    bus.req1_valid = 0;
    @(negedge clk);
    n_tests++; if (bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b want 0", bus.rf_reg_write); end
    n_tests++; if (bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL x0_mask: got %h want 0", bus.pending_mask); end
    tick();
    bus.req0_valid = 1; bus.req0_rd = 5'd1; bus.req0_data = 32'h11;
    bus.req1_valid = 1; bus.req1_rd = 5'd2; bus.req1_data = 32'h22;
    @(negedge clk);
    n_tests++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL x0_next_ready0: got %b want 1", bus.req0_ready); end
    n_tests++; if (bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL x0_next_ready1: got %b want 0", bus.req1_ready); end
    n_tests++; if (bus.write_count !== 4'd0) begin n_fail++; $display("FAIL x0_count: got %0d want 0", bus.write_count); end
    tick();
    clear_inputs();
  endtask

  task automatic test_hold();
    do_reset();
    bus.req0_valid = 1; bus.req0_rd = 5'd7; bus.req0_data = 32'h55;
    @(negedge clk);
    n_tests++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL hold_accept: got %b want 1", bus.req0_ready); end
    tick();
    bus.hold = 1;
    bus.req0_rd = 5'd10; bus.req0_data = 32'hA0;
    bus.req1_valid = 1; bus.req1_rd = 5'd11; bus.req1_data = 32'hB0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_tests++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin n_fail++; $display("FAIL hold_ready[%0d]: got %b%b want 00", k, bus.req0_ready, bus.req1_ready); end
      n_tests++; if (bus.rf_reg_write !== 1'b0) begin n_fail++; $display("FAIL hold_we[%0d]: got %b want 0", k, bus.rf_reg_write); end
      n_tests++; if (bus.fwd_rd !== 5'd7 || bus.fwd_valid !== 1'b1) begin n_fail++; $display("FAIL hold_fwd[%0d]: got v%b rd %0d want v1 rd 7", k, bus.fwd_valid, bus.fwd_rd); end
      n_tests++; if (bus.pending_mask !== 32'h80) begin n_fail++; $display("FAIL hold_mask[%0d]: got %h want 00000080", k, bus.pending_mask); end
      n_tests++; if (bus.write_count !== 4'd0) begin n_fail++; $display("FAIL hold_count[%0d]: got %0d want 0", k, bus.write_count); end
      tick();
    end
    bus.hold = 0;
    @(negedge clk);
    n_tests++; if (bus.rf_reg_write !== 1'b1 || bus.rf_write_reg !== 5'd7) begin n_fail++; $display("FAIL unhold_we: got %b rd %0d want 1 rd 7", bus.rf_reg_write, bus.rf_write_reg); end
    n_tests++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL unhold_ready: got %b%b want 01", bus.req0_ready, bus.req1_ready); end
    tick();
    bus.req1_valid = 0;
    bus.req0_valid = 0;
    @(negedge clk);
    n_tests++; if (bus.rf_write_reg !== 5'd11 || bus.write_count !== 4'd1) begin n_fail++; $display("FAIL unhold_next: got rd %0d count %0d want rd 11 count 1", bus.rf_write_reg, bus.write_count); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    written[9] = 1'b0;
    bus.req0_valid = 1; bus.req0_rd = 5'd9; bus.req0_data = 32'h99;
    @(negedge clk);
    n_tests++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL mid_accept: got %b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 0;
    #1;
    n_tests++; if (bus.rf_reg_write !== 1'b1) begin n_fail++; $display("FAIL mid_pre_we: got %b want 1", bus.rf_reg_write); end
    #1;
    reset = 1;
    model_reset();
    #1;
    n_tests++; if (bus.rf_reg_write !== 1'b0 || bus.pending_mask !== 32'd0) begin n_fail++; $display("FAIL mid_drop: got we %b mask %h want 0 0", bus.rf_reg_write, bus.pending_mask); end
    @(posedge clk); #1;
    reset = 0;
    bus.req0_valid = 1; bus.req0_rd = 5'd1; bus.req0_data = 32'h1;
    bus.req1_valid = 1; bus.req1_rd = 5'd2; bus.req1_data = 32'h2;
    @(negedge clk);
    n_tests++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL mid_conflict: got %b%b want 10", bus.req0_ready, bus.req1_ready); end
    n_tests++; if (written[9] !== 1'b0) begin n_fail++; $display("FAIL mid_x9: got written %b want 0", written[9]); end
    tick();
    clear_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 18; i++) begin
      bus.req0_valid = 1; bus.req0_rd = 5'((i % 31) + 1); bus.req0_data = 32'(i);
      tick();
    end
    bus.req0_valid = 0;
    @(negedge clk);
    n_tests++; if (bus.write_count !== 4'd1) begin n_fail++; $display("FAIL wrap_17: got %0d want 1", bus.write_count); end
    tick();
    @(negedge clk);
    n_tests++; if (bus.write_count !== 4'd2) begin n_fail++; $display("FAIL wrap_18: got %0d want 2", bus.write_count); end
  endtask

  task automatic test_random();
    wb_req_t q0, q1;
    int w;
    do_reset();
    q0 = '0; q1 = '0;
    for (int c = 0; c < 300; c++) begin
      if (!q0.valid && $urandom_range(0, 2) != 0) begin q0.valid = 1; q0.rd = 5'($urandom_range(0, 31)); q0.data = $urandom; end
      if (!q1.valid && $urandom_range(0, 2) != 0) begin q1.valid = 1; q1.rd = 5'($urandom_range(0, 31)); q1.data = $urandom; end
      bus.req0_valid = q0.valid; bus.req0_rd = q0.rd; bus.req0_data = q0.data;
      bus.req1_valid = q1.valid; bus.req1_rd = q1.rd; bus.req1_data = q1.data;
      bus.hold = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      w = winner();
      n_tests++; if (bus.req0_ready !== (w == 0) || bus.req1_ready !== (w == 1)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", c, bus.req0_ready, bus.req1_ready, w == 0, w == 1); end
      n_tests++; if (bus.rf_reg_write !== (m_pv && !bus.hold)) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b want %b", c, bus.rf_reg_write, m_pv && !bus.hold); end
      n_tests++; if (bus.rf_write_reg !== m_prd || bus.rf_write_data !== m_pdata) begin n_fail++; $display("FAIL rnd_port[%0d]: got rd %0d data %h want rd %0d data %h", c, bus.rf_write_reg, bus.rf_write_data, m_prd, m_pdata); end
      n_tests++; if (bus.fwd_valid !== m_pv || bus.fwd_rd !== m_prd || bus.fwd_data !== m_pdata) begin n_fail++; $display("FAIL rnd_fwd[%0d]: got v%b rd %0d want v%b rd %0d", c, bus.fwd_valid, bus.fwd_rd, m_pv, m_prd); end
      n_tests++; if (bus.pending_mask !== (m_pv ? (32'd1 << m_prd) : 32'd0)) begin n_fail++; $display("FAIL rnd_mask[%0d]: got %h want %h", c, bus.pending_mask, m_pv ? (32'd1 << m_prd) : 32'd0); end
      n_tests++; if (bus.write_count !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, bus.write_count, m_cnt); end
      if (w == 0) q0.valid = 0;
      if (w == 1) q1.valid = 0;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_x0();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
